// File: rtl/load_store_unit_if.sv
// Request/response handshake from the execute stage plus the word-addressed bus to mmu.
// The slave modport is the load/store unit; the master side is the core and mmu together.
interface load_store_unit_if;
  logic        reqValid;
  logic        reqReady;
  logic        reqWrite;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        respValid;
  logic [31:0] rdata;
  logic        misaligned;
  logic        illegal;
  logic [31:0] faultAddr;
  logic [31:0] vaddr;
  logic [31:0] data;
  logic [3:0]  byteena;
  logic        memWE;
  logic [31:0] q;

  modport master (
    output reqValid, reqWrite, funct3, addr, wdata, q,
    input  reqReady, respValid, rdata, misaligned, illegal, faultAddr,
           vaddr, data, byteena, memWE
  );

  modport slave (
    input  reqValid, reqWrite, funct3, addr, wdata, q,
    output reqReady, respValid, rdata, misaligned, illegal, faultAddr,
           vaddr, data, byteena, memWE
  );
endinterface

// File: rtl/load_store_unit.sv
// RV32I load/store sequencer in front of mmu: lane placement for stores, fixed-latency
// read with lane extraction and sign/zero extension for loads, fault flagging without access.
module load_store_unit #(
  parameter int unsigned READ_LATENCY = 3
) (
  input logic              clock,
  input logic              RST,
  load_store_unit_if.slave bus
);

  typedef enum logic [1:0] {IDLE, STORE, LOAD, RESP} state_t;

  localparam int unsigned CW = (READ_LATENCY < 1) ? 1 : $clog2(READ_LATENCY + 1);
  localparam logic [CW-1:0] LAST = CW'(READ_LATENCY);

  state_t      state;
  logic [CW-1:0] cnt;
  logic [2:0]  capFunct3;
  logic [1:0]  capAddrLo;

  logic        illegalReq;
  logic        misalignedReq;
  logic [3:0]  storeBe;
  logic [31:0] storeData;
  logic [31:0] lane;
  logic [31:0] laneExt;

  // Request decode, evaluated against the live request fields in IDLE.
  always_comb begin
    illegalReq    = 1'b0;
    misalignedReq = 1'b0;
    storeBe       = '0;
    storeData     = '0;

    if (bus.reqWrite) illegalReq = (bus.funct3 >= 3'd3);
    else              illegalReq = (bus.funct3 == 3'd3) || (bus.funct3[2:1] == 2'b11);

    case (bus.funct3[1:0])
      2'b01:   misalignedReq = bus.addr[0];
      2'b10:   misalignedReq = (bus.addr[1:0] != 2'b00);
      default: misalignedReq = 1'b0;
    endcase

    case (bus.funct3[1:0])
      2'b00: begin
        storeBe   = 4'b0001 << bus.addr[1:0];
        storeData = {4{bus.wdata[7:0]}};
      end
      2'b01: begin
        storeBe   = 4'b0011 << bus.addr[1:0];
        storeData = {2{bus.wdata[15:0]}};
      end
      default: begin
        storeBe   = 4'b1111;
        storeData = bus.wdata;
      end
    endcase
  end

  // Lane extraction from the returned word using the captured request.
  always_comb begin
    lane = bus.q >> {capAddrLo, 3'b000};
    case (capFunct3)
      3'd0:    laneExt = {{24{lane[7]}}, lane[7:0]};
      3'd1:    laneExt = {{16{lane[15]}}, lane[15:0]};
      3'd4:    laneExt = {24'h0, lane[7:0]};
      3'd5:    laneExt = {16'h0, lane[15:0]};
      default: laneExt = lane;
    endcase
  end

  always_ff @(posedge clock) begin
    if (RST) begin
      state          <= IDLE;
      cnt            <= '0;
      capFunct3      <= '0;
      capAddrLo      <= '0;
      bus.reqReady   <= 1'b1;
      bus.respValid  <= 1'b0;
      bus.rdata      <= '0;
      bus.misaligned <= 1'b0;
      bus.illegal    <= 1'b0;
      bus.faultAddr  <= '0;
      bus.vaddr      <= '0;
      bus.data       <= '0;
      bus.byteena    <= '0;
      bus.memWE      <= 1'b0;
    end else begin
      // Pulses and write strobes drop unless a branch below re-asserts them.
      bus.respValid  <= 1'b0;
      bus.misaligned <= 1'b0;
      bus.illegal    <= 1'b0;
      bus.memWE      <= 1'b0;
      bus.byteena    <= '0;

      case (state)
        IDLE: begin
          if (bus.reqValid) begin
            if (illegalReq) begin
              bus.illegal   <= 1'b1;
              bus.faultAddr <= bus.addr;
            end else if (misalignedReq) begin
              bus.misaligned <= 1'b1;
              bus.faultAddr  <= bus.addr;
            end else if (bus.reqWrite) begin
              state         <= STORE;
              bus.reqReady  <= 1'b0;
              bus.vaddr     <= bus.addr;
              bus.data      <= storeData;
              bus.byteena   <= storeBe;
              bus.memWE     <= 1'b1;
              bus.respValid <= 1'b1;
              bus.rdata     <= '0;
            end else begin
              state        <= LOAD;
              bus.reqReady <= 1'b0;
              bus.vaddr    <= bus.addr;
              cnt          <= '0;
              capFunct3    <= bus.funct3;
              capAddrLo    <= bus.addr[1:0];
            end
          end
        end

        STORE: begin
          state        <= IDLE;
          bus.reqReady <= 1'b1;
        end

        LOAD: begin
          if (cnt == LAST) begin
            bus.rdata     <= laneExt;
            bus.respValid <= 1'b1;
            state         <= RESP;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        RESP: begin
          state        <= IDLE;
          bus.reqReady <= 1'b1;
        end

        default: begin
          state        <= IDLE;
          bus.reqReady <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Sits between the core's execute stage and `mmu`. Turns one RV32I load/store request into the word-addressed `vaddr`/`data`/`byteena`/`memWE` stimulus that `mmu` expects. Holds the address stable for the fixed read latency of the `mmu`+`mockram` path, then extracts and sign- or zero-extends the returned lane. Flags misaligned and illegal accesses without touching memory.

## Interface
- `READ_LATENCY`, default 3: cycles from the first cycle `vaddr` is driven to the cycle `q` carries that address's data (must be ≥1).
- `clock`  in  1  system clock; the same clock that drives `mmu`.
- `RST`  in  1  synchronous, active-high reset.
- `reqValid`  in  1  request present.
- `reqReady`  out  1  unit idle, accepts request this cycle.
- `reqWrite`  in  1  1 = store, 0 = load.
- `funct3`  in  3  RV32I width/sign code (0 B, 1 H, 2 W, 4 BU, 5 HU).
- `addr`  in  32  byte address.
- `wdata`  in  32  store data, right-aligned.
- `respValid`  out  1  one-cycle pulse: access completed (loads and stores).
- `rdata`  out  32  extended load result; valid with `respValid`.
- `misaligned`  out  1  one-cycle pulse: alignment fault, no access made.
- `illegal`  out  1  one-cycle pulse: unsupported `funct3`, no access made.
- `faultAddr`  out  32  `addr` of the faulting request; valid with `misaligned`/`illegal`.
- `vaddr`  out  32  to `mmu`.
- `data`  out  32  to `mmu`, lane-replicated store data.
- `byteena`  out  4  to `mmu`.
- `memWE`  out  1  to `mmu`.
- `q`  in  32  from `mmu`.

## Operation
- **FSM states:** IDLE, STORE, LOAD, RESP.
- **Ready / handshake:** `reqReady` = 1 only in IDLE. A request is accepted on `reqValid && reqReady` and all request fields are captured at that edge.
- **Checks at acceptance, in priority order:**
  - Illegal: load `funct3` ∈ {3,6,7}, or store `funct3` ≥ 3. Result: `illegal` pulse, `faultAddr` = `addr`, stay in IDLE.
  - Misaligned: H/HU with `addr[0]`=1, or W with `addr[1:0]`≠0. Result: `misaligned` pulse, `faultAddr` = `addr`, stay in IDLE.
  - No `mmu` signal changes in either fault case.
- **Store path:** go to STORE.
  - `vaddr` = `addr`.
  - `byteena`: SB = 4'b0001<<`addr[1:0]`; SH = 4'b0011<<`addr[1:0]`; SW = 4'b1111.
  - `data`: SB = {4{`wdata[7:0]`}}; SH = {2{`wdata[15:0]`}}; SW = `wdata`.
  - `memWE` = 1 for exactly the STORE cycle; `respValid` pulses in that same cycle, `rdata` = 0. Then return to IDLE.
- **Load path:** go to LOAD.
  - `vaddr` = `addr` held for `READ_LATENCY`+1 cycles; `memWE` = 0, `byteena` = 0.
  - An internal counter counts 0..`READ_LATENCY`. At count = `READ_LATENCY`, `q` is sampled and the state moves to RESP.
  - Lane = `q` >> (8*`addr[1:0]`).
  - B/H results are sign-extended from bit 7/15; BU/HU results are zero-extended; W passes through.
- **RESP:** `respValid` = 1 with `rdata`, then return to IDLE.
- **Idle outputs:** `memWE` = 0, `byteena` = 0, `vaddr` and `data` hold their last values. This keeps `mmu`'s UART decode from seeing spurious addresses.
- **Reset values:** `reqReady` 1 after reset, state IDLE. `vaddr`, `data`, `rdata`, `faultAddr` = 0; `byteena` = 0; `memWE`, `respValid`, `misaligned`, `illegal` = 0.
- **Reset mid-operation:** the FSM returns to IDLE at the next edge. No `respValid` is issued for the aborted access, and `memWE` is 0 from the following cycle.
- **Requests while busy:** `reqValid` while busy is ignored; the requester must hold it.

## Timing
- Acceptance edge = end of cycle T.
- **Store:** `memWE`/`byteena`/`data`/`vaddr` driven in T+1; `respValid` in T+1; `reqReady` back to 1 in T+2.
- **Load:** `vaddr` driven from T+1; `q` sampled at the end of T+1+`READ_LATENCY`; `respValid` in T+2+`READ_LATENCY`; `reqReady` in T+3+`READ_LATENCY`.
  - With the default (3): response in T+5, next acceptance possible at end of T+6.
- **Faults:** `misaligned`/`illegal` in T+1; `reqReady` remains 1 throughout, so back-to-back requests are allowed.
- All outputs are registered; there are no combinational paths from `q` or `req*` to any output.

## Test plan
- **Reset:** hold `RST` 2 cycles → all outputs 0 and `reqReady`=1 on the first cycle after release.
- **SB:** `addr`=0x103, `wdata`=0xAABBCCDD → in T+1: `byteena`=4'b1000, `data`=0xDDDDDDDD, `memWE`=1, `respValid`=1. `memWE`=0 in T+2.
- **LB vs LBU:** preload word 0x80 with 0x12F4_5678, load `addr`=0x82 with `READ_LATENCY`=3.
  - LB → `rdata`=0xFFFFFFF4 with `respValid` in T+5.
  - LBU → `rdata`=0x000000F4.
  - `vaddr`=0x82 stable T+1..T+4.
- **SW/LW round trip:** SW 0xDEADBEEF to 0x40, then LW 0x40 → `rdata`=0xDEADBEEF.
- **Faults:** LW to 0x41 → `misaligned` pulse, `faultAddr`=0x41, no `memWE`. A store with `funct3`=4 at the next cycle → `illegal` pulse, no access.
- **Reset mid-load:** assert `RST` at T+2 of an LH → no `respValid` ever; `reqReady`=1 after reset; a fresh LW completes normally.
